sort_job_scheduler: RTL and testbench

//  Job controller wrapping bitonic_sorter and its 2-port data RAM. Sequences LOAD (stream in),

---
 rtl/sort_job_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_sort_job_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sort_job_scheduler
// Description : Job controller around a bitonic sorter and its 2-port data
//               RAM. A job is streamed into the RAM (LOAD), sorted in place
//               by the sorter (SORT), then streamed back out (DRAIN). The RAM
//               ports are steered to the loader/drainer or to the sorter
//               depending on the phase. One job in flight at a time.
//               Optional feature macro: SORT_SCHED_CYCLE_COUNT_EN adds the
//               sort_cycles_o output (cycles spent waiting on the sorter).
// Revision    : 1.0 - initial release
// ============================================================================
module sort_job_scheduler #(
    parameter int DATA_ADDR_BITS = 13,
    parameter int DATA_WIDTH     = 64,
    parameter int MAX_NUM_VALUES = 8192
) (
    input  logic                      clk,
    input  logic                      rst,
    // load stream
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DATA_WIDTH-1:0]     in_data_i,
    input  logic                      in_last_i,
    // drain stream
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_WIDTH-1:0]     out_data_o,
    output logic                      out_last_o,
    // sorter control
    output logic                      sort_rst_o,
    output logic                      sort_start_o,
    output logic [DATA_ADDR_BITS:0]   sort_num_values_o,
    input  logic                      sort_done_i,
    // sorter-side RAM requests
    input  logic                      srt_we_a_i,
    input  logic [DATA_ADDR_BITS-1:0] srt_w_addr_a_i,
    input  logic [DATA_WIDTH-1:0]     srt_w_data_a_i,
    input  logic [DATA_ADDR_BITS-1:0] srt_r_addr_a_i,
    input  logic                      srt_we_b_i,
    input  logic [DATA_ADDR_BITS-1:0] srt_w_addr_b_i,
    input  logic [DATA_WIDTH-1:0]     srt_w_data_b_i,
    input  logic [DATA_ADDR_BITS-1:0] srt_r_addr_b_i,
    // RAM ports
    output logic                      ram_we_a_o,
    output logic [DATA_ADDR_BITS-1:0] ram_w_addr_a_o,
    output logic [DATA_WIDTH-1:0]     ram_w_data_a_o,
    output logic [DATA_ADDR_BITS-1:0] ram_r_addr_a_o,
    input  logic [DATA_WIDTH-1:0]     ram_r_data_a_i,
    output logic                      ram_we_b_o,
    output logic [DATA_ADDR_BITS-1:0] ram_w_addr_b_o,
    output logic [DATA_WIDTH-1:0]     ram_w_data_b_o,
    output logic [DATA_ADDR_BITS-1:0] ram_r_addr_b_o,
    input  logic [DATA_WIDTH-1:0]     ram_r_data_b_i,
    // status
    output logic                      busy_o,
    output logic                      overflow_o
`ifdef SORT_SCHED_CYCLE_COUNT_EN
    ,
    output logic [31:0]               sort_cycles_o
`endif
);

    localparam int                CNT_W   = DATA_ADDR_BITS + 1;
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_NUM_VALUES);
    localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_SORT_RST   = 3'd2,
        ST_SORT_START = 3'd3,
        ST_SORT_WAIT  = 3'd4,
        ST_DRAIN_ADDR = 3'd5,
        ST_DRAIN_WAIT = 3'd6,
        ST_DRAIN_HOLD = 3'd7
    } state_t;

    state_t                    state_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic                      out_last_q;
    logic [DATA_WIDTH-1:0]     out_data_q;
    logic                      sort_rst_q;
    logic                      sort_start_q;
    logic [CNT_W-1:0]          sort_num_q;
    logic                      overflow_q;
    logic [CNT_W-1:0]          count_q;
    logic [CNT_W-1:0]          idx_q;
    logic                      load_we_q;
    logic [DATA_ADDR_BITS-1:0] load_addr_q;
    logic [DATA_WIDTH-1:0]     load_data_q;
    logic                      sel_sort;

    // Job sequencer: all handshake, control and load-write outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            sort_rst_q   <= 1'b1;
            sort_start_q <= 1'b0;
            sort_num_q   <= '0;
            overflow_q   <= 1'b0;
            count_q      <= '0;
            idx_q        <= '0;
            load_we_q    <= 1'b0;
            load_addr_q  <= '0;
            load_data_q  <= '0;
        end else begin
            // single-cycle pulses default low
            load_we_q    <= 1'b0;
            sort_rst_q   <= 1'b0;
            sort_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    count_q    <= '0;
                    in_ready_q <= 1'b1;
                    state_q    <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (in_valid_i && in_ready_q) begin
                        load_we_q   <= 1'b1;
                        load_addr_q <= count_q[DATA_ADDR_BITS-1:0];
                        load_data_q <= in_data_i;
                        count_q     <= count_q + ONE;
                        // a new job starts with a clean overflow flag
                        if (count_q == '0) begin
                            overflow_q <= 1'b0;
                        end
                        if (in_last_i || (count_q + ONE == MAX_CNT)) begin
                            in_ready_q <= 1'b0;
                            sort_rst_q <= 1'b1;
                            state_q    <= ST_SORT_RST;
                            // full without a last marker: job is truncated
                            if (!in_last_i) begin
                                overflow_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_SORT_RST: begin
                    // a single element is already sorted and the sorter would not terminate on it
                    if (count_q == ONE) begin
                        idx_q   <= '0;
                        state_q <= ST_DRAIN_ADDR;
                    end else begin
                        sort_start_q <= 1'b1;
                        sort_num_q   <= count_q;
                        state_q      <= ST_SORT_START;
                    end
                end
                ST_SORT_START: begin
                    state_q <= ST_SORT_WAIT;
                end
                ST_SORT_WAIT: begin
                    if (sort_done_i) begin
                        idx_q   <= '0;
                        state_q <= ST_DRAIN_ADDR;
                    end
                end
                ST_DRAIN_ADDR: begin
                    state_q <= ST_DRAIN_WAIT;
                end
                ST_DRAIN_WAIT: begin
                    // read data for idx arrives one cycle after the address
                    out_data_q  <= ram_r_data_a_i;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (idx_q == count_q - ONE);
                    state_q     <= ST_DRAIN_HOLD;
                end
                ST_DRAIN_HOLD: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        idx_q       <= idx_q + ONE;
                        state_q     <= out_last_q ? ST_IDLE : ST_DRAIN_ADDR;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel_sort = (state_q == ST_SORT_WAIT);

    // RAM port steering: the sorter owns both ports only while it is running.
    always_comb begin
        ram_we_a_o     = load_we_q;
        ram_w_addr_a_o = load_addr_q;
        ram_w_data_a_o = load_data_q;
        ram_r_addr_a_o = idx_q[DATA_ADDR_BITS-1:0];
        ram_we_b_o     = 1'b0;
        ram_w_addr_b_o = '0;
        ram_w_data_b_o = '0;
        ram_r_addr_b_o = '0;
        if (sel_sort) begin
            ram_we_a_o     = srt_we_a_i;
            ram_w_addr_a_o = srt_w_addr_a_i;
            ram_w_data_a_o = srt_w_data_a_i;
            ram_r_addr_a_o = srt_r_addr_a_i;
            ram_we_b_o     = srt_we_b_i;
            ram_w_addr_b_o = srt_w_addr_b_i;
            ram_w_data_b_o = srt_w_data_b_i;
            ram_r_addr_b_o = srt_r_addr_b_i;
        end
    end

    // Port B read data is consumed by the sorter directly, never by the drain path.
    logic unused_rd_b;
    assign unused_rd_b = ^ram_r_data_b_i;

    assign in_ready_o        = in_ready_q;
    assign out_valid_o       = out_valid_q;
    assign out_last_o        = out_last_q;
    assign out_data_o        = out_data_q;
    assign sort_rst_o        = sort_rst_q;
    assign sort_start_o      = sort_start_q;
    assign sort_num_values_o = sort_num_q;
    assign overflow_o        = overflow_q;
    assign busy_o            = (state_q != ST_IDLE);

`ifdef SORT_SCHED_CYCLE_COUNT_EN
    logic [31:0] sort_cycles_q;

    // Saturating count of cycles spent waiting for the sorter in the current job.
    always_ff @(posedge clk) begin
        if (rst) begin
            sort_cycles_q <= '0;
        end else if (state_q == ST_SORT_START) begin
            sort_cycles_q <= '0;
        end else if (sel_sort && (sort_cycles_q != 32'hFFFF_FFFF)) begin
            sort_cycles_q <= sort_cycles_q + 32'd1;
        end
    end

    assign sort_cycles_o = sort_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sort_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_job_scheduler
// Description : Self-checking bench for sort_job_scheduler with a behavioural
//               2-port RAM and an odd-even transposition sorter model that
//               works through the scheduler's sorter-side RAM ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_job_scheduler;

    localparam int AB  = 4;
    localparam int DW  = 16;
    localparam int MAX = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, in_last;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] out_data;
    logic          sort_rst, sort_start, sort_done;
    logic [AB:0]   sort_num_values;
    logic          srt_we_a, srt_we_b;
    logic [AB-1:0] srt_w_addr_a, srt_r_addr_a, srt_w_addr_b, srt_r_addr_b;
    logic [DW-1:0] srt_w_data_a, srt_w_data_b;
    logic          ram_we_a, ram_we_b;
    logic [AB-1:0] ram_w_addr_a, ram_r_addr_a, ram_w_addr_b, ram_r_addr_b;
    logic [DW-1:0] ram_w_data_a, ram_w_data_b, ram_r_data_a, ram_r_data_b;
    logic          busy, overflow;
`ifdef SORT_SCHED_CYCLE_COUNT_EN
    logic [31:0]   sort_cycles;
`endif

    sort_job_scheduler #(
        .DATA_ADDR_BITS(AB),
        .DATA_WIDTH    (DW),
        .MAX_NUM_VALUES(MAX)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_data_i        (in_data),
        .in_last_i        (in_last),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_data_o       (out_data),
        .out_last_o       (out_last),
        .sort_rst_o       (sort_rst),
        .sort_start_o     (sort_start),
        .sort_num_values_o(sort_num_values),
        .sort_done_i      (sort_done),
        .srt_we_a_i       (srt_we_a),
        .srt_w_addr_a_i   (srt_w_addr_a),
        .srt_w_data_a_i   (srt_w_data_a),
        .srt_r_addr_a_i   (srt_r_addr_a),
        .srt_we_b_i       (srt_we_b),
        .srt_w_addr_b_i   (srt_w_addr_b),
        .srt_w_data_b_i   (srt_w_data_b),
        .srt_r_addr_b_i   (srt_r_addr_b),
        .ram_we_a_o       (ram_we_a),
        .ram_w_addr_a_o   (ram_w_addr_a),
        .ram_w_data_a_o   (ram_w_data_a),
        .ram_r_addr_a_o   (ram_r_addr_a),
        .ram_r_data_a_i   (ram_r_data_a),
        .ram_we_b_o       (ram_we_b),
        .ram_w_addr_b_o   (ram_w_addr_b),
        .ram_w_data_b_o   (ram_w_data_b),
        .ram_r_addr_b_o   (ram_r_addr_b),
        .ram_r_data_b_i   (ram_r_data_b),
        .busy_o           (busy),
        .overflow_o       (overflow)
`ifdef SORT_SCHED_CYCLE_COUNT_EN
        ,
        .sort_cycles_o    (sort_cycles)
`endif
    );

    // 2-port RAM model with one cycle of read latency
    logic [DW-1:0] mem [0:(1<<AB)-1];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_w_addr_a] <= ram_w_data_a;
        if (ram_we_b) mem[ram_w_addr_b] <= ram_w_data_b;
        ram_r_data_a <= mem[ram_r_addr_a];
        ram_r_data_b <= mem[ram_r_addr_b];
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // sort_rst must precede every sort_start
    int n_start     = 0;
    int n_order_err = 0;
    bit rst_seen    = 1'b0;
    always @(posedge clk) begin
        if (sort_rst) begin
            rst_seen <= 1'b1;
        end else if (sort_start) begin
            rst_seen <= 1'b0;
            n_start  <= n_start + 1;
            if (!rst_seen) n_order_err <= n_order_err + 1;
        end
    end

    // ---------------- sorter model ----------------
    task automatic srt_idle();
        srt_we_a = 1'b0; srt_w_addr_a = '0; srt_w_data_a = '0; srt_r_addr_a = '0;
        srt_we_b = 1'b0; srt_w_addr_b = '0; srt_w_data_b = '0; srt_r_addr_b = '0;
        sort_done = 1'b0;
    endtask

    task automatic run_sort(input int n);
        logic [DW-1:0] a, b;
        @(negedge clk);
        for (int p = 0; p < n; p++) begin
            for (int i = p % 2; i + 1 < n; i += 2) begin
                srt_r_addr_a = AB'(i);
                srt_r_addr_b = AB'(i + 1);
                @(negedge clk);
                if (sort_rst) begin srt_idle(); return; end
                a = ram_r_data_a;
                b = ram_r_data_b;
                if (a > b) begin
                    srt_we_a = 1'b1; srt_w_addr_a = AB'(i);     srt_w_data_a = b;
                    srt_we_b = 1'b1; srt_w_addr_b = AB'(i + 1); srt_w_data_b = a;
                end
                @(negedge clk);
                srt_we_a = 1'b0;
                srt_we_b = 1'b0;
                if (sort_rst) begin srt_idle(); return; end
            end
        end
        sort_done = 1'b1;
        @(negedge clk);
        if (sort_rst) begin srt_idle(); return; end
        // stray requests after done: the scheduler must ignore them
        srt_we_a = 1'b1; srt_w_addr_a = AB'(1); srt_w_data_a = 16'hBEEF;
        srt_we_b = 1'b1; srt_w_addr_b = AB'(0); srt_w_data_b = 16'hDEAD;
        srt_r_addr_a = AB'(MAX - 1);
    endtask

    initial begin
        srt_idle();
        forever begin
            @(negedge clk);
            if (sort_rst) srt_idle();
            else if (sort_start) run_sort(int'(sort_num_values));
        end
    end

    // ---------------- scoreboard & stimulus ----------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;
    exp_t sb[$];
    int   job[$];

    task automatic push_sorted(input int n);
        int tmp[$];
        int t;
        for (int k = 0; k < n; k++) tmp.push_back(job[k]);
        for (int i = 1; i < n; i++) begin
            for (int j = i; j > 0 && tmp[j-1] > tmp[j]; j--) begin
                t = tmp[j]; tmp[j] = tmp[j-1]; tmp[j-1] = t;
            end
        end
        for (int k = 0; k < n; k++) sb.push_back('{data: DW'(tmp[k]), last: (k == n - 1)});
    endtask

    task automatic load_job(input bit with_last, output int accepted);
        int waited;
        accepted = 0;
        for (int k = 0; k < job.size(); k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DW'(job[k]);
            in_last  = with_last && (k == job.size() - 1);
            waited   = 0;
            while (!in_ready && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            if (in_ready) begin
                @(posedge clk);
                accepted++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input int n, input int stall_at);
        int            w;
        bit            stable;
        logic [DW-1:0] d0;
        exp_t          e;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (!out_valid && w < 300) begin
                @(negedge clk);
                w++;
            end
            if (!out_valid) begin
                check_val("drain_timeout", 64'(out_valid), 64'd1);
                return;
            end
            if (k == 0) check_val("ram_we_b_gated", 64'(ram_we_b), 64'd0);
            if (k == stall_at) begin
                d0     = out_data;
                stable = 1'b1;
                for (int s = 0; s < 10; s++) begin
                    @(negedge clk);
                    if (out_valid !== 1'b1 || out_data !== d0) stable = 1'b0;
                end
                check_val("stall_stable", 64'(stable), 64'd1);
            end
            if (sb.size() == 0) begin
                check_val("sb_empty", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                return;
            end
            e = sb.pop_front();
            check_val("out_data", 64'(out_data), 64'(e.data));
            check_val("out_last", 64'(out_last), 64'(e.last));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    int acc;
    int starts0;
    int w0;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready",   64'(in_ready),   64'd0);
        check_val("rst_out_valid",  64'(out_valid),  64'd0);
        check_val("rst_out_last",   64'(out_last),   64'd0);
        check_val("rst_sort_rst",   64'(sort_rst),   64'd1);
        check_val("rst_sort_start", 64'(sort_start), 64'd0);
        check_val("rst_busy",       64'(busy),       64'd0);
        check_val("rst_overflow",   64'(overflow),   64'd0);
        check_val("rst_ram_we_a",   64'(ram_we_a),   64'd0);
        check_val("rst_ram_we_b",   64'(ram_we_b),   64'd0);
        rst = 1'b0;

        // basic five-element job with a stall on the third output
        job = '{5, 1, 4, 2, 3};
        push_sorted(5);
        load_job(1'b1, acc);
        check_val("j1_accepted", 64'(acc), 64'd5);
        drain(5, 2);
        check_val("j1_num_values", 64'(sort_num_values), 64'd5);
        check_val("j1_starts", 64'(n_start), 64'd1);
        check_val("j1_busy_idle", 64'(busy), 64'd0);
`ifdef SORT_SCHED_CYCLE_COUNT_EN
        check_val("j1_cycles_nz", 64'(sort_cycles != 0), 64'd1);
`endif

        // single element: sort skipped
        starts0 = n_start;
        job = '{7};
        push_sorted(1);
        load_job(1'b1, acc);
        drain(1, -1);
        check_val("j2_no_start", 64'(n_start), 64'(starts0));
        check_val("j2_busy_idle", 64'(busy), 64'd0);

        // overflow: ten elements without last, only MAX kept
        job = '{9, 3, 12, 0, 7, 7, 1, 15, 100, 200};
        push_sorted(MAX);
        load_job(1'b0, acc);
        check_val("j3_accepted", 64'(acc), 64'(MAX));
        check_val("j3_overflow", 64'(overflow), 64'd1);
        drain(MAX, -1);
        check_val("j3_overflow_sticky", 64'(overflow), 64'd1);
        check_val("j3_num_values", 64'(sort_num_values), 64'(MAX));

        // reset in the middle of a sort
        job = '{30, 10, 20, 40, 5};
        load_job(1'b1, acc);
        check_val("j4_overflow_clr", 64'(overflow), 64'd0);
        w0 = 0;
        while (!sort_start && w0 < 50) begin
            @(negedge clk);
            w0++;
        end
        check_val("j4_start_seen", 64'(sort_start), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("j4_rst_busy",      64'(busy),      64'd0);
        check_val("j4_rst_sort_rst",  64'(sort_rst),  64'd1);
        check_val("j4_rst_in_ready",  64'(in_ready),  64'd0);
        check_val("j4_rst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        job = '{2, 1};
        push_sorted(2);
        load_job(1'b1, acc);
        drain(2, -1);

        // two back-to-back jobs
        starts0 = n_start;
        job = '{6, 5, 4};
        push_sorted(3);
        load_job(1'b1, acc);
        drain(3, -1);
        job = '{1, 3, 2, 0};
        push_sorted(4);
        load_job(1'b1, acc);
        drain(4, -1);
        check_val("b2b_starts", 64'(n_start - starts0), 64'd2);
        check_val("order_rst_before_start", 64'(n_order_err), 64'd0);
        check_val("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
